// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Bundles the signals between the pipeline stages and the central stall
// sequencer.
//   stallreq_if  : fetch stage not ready (level)
//   stallreq_id  : load-use hazard in id (level)
//   ex_mc_start  : one-cycle pulse, ex begins a multi-cycle op
//   ex_mc_len    : cycle count of that op, sampled with ex_mc_start
//   mem_req      : mem stage has a data-memory access in flight (level)
//   mem_ack      : data memory completes the access this cycle
//   stall        : stall vector, bit0 pc .. bit5 wb, 1 = stop
//   ex_mc_busy   : multi-cycle op in progress
//   ex_mc_done   : one-cycle pulse when the op completes
//   mem_timeout  : one-cycle pulse when a mem wait is abandoned by the watchdog
//   stall_cycles : stall statistics counter
// Modports: master = pipeline side (drives requests), slave = sequencer.
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_len;
  logic        mem_req;
  logic        mem_ack;
  logic [5:0]  stall;
  logic        ex_mc_busy;
  logic        ex_mc_done;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, ex_mc_start, ex_mc_len, mem_req, mem_ack,
    input  stall, ex_mc_busy, ex_mc_done, mem_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, ex_mc_start, ex_mc_len, mem_req, mem_ack,
    output stall, ex_mc_busy, ex_mc_done, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall sequencer for the six-stage pipeline (pc, if, id, ex, mem,
// wb). Combines fetch/decode stall requests, an ex multi-cycle down-counter
// and a mem wait FSM with timeout watchdog into one stall vector where the
// latest stalled stage wins.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-low reset (0 = reset); forces stall to zero
//   sb  : pipe_stall_ctrl_if.slave handshake bundle (see interface header)
// Parameters:
//   MEM_TIMEOUT : max consecutive mem-wait stall cycles (2..255)
//   CNT_W       : width of the mem wait counter
// Optional feature:
//   STALL_STAT_EN : when defined, stall_cycles counts stalled cycles
//                   (saturating); otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.slave  sb
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MEM_TIMEOUT);

  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;

  // ---- ex multi-cycle engine ----------------------------------------------
  logic       ex_busy;
  logic [5:0] ex_cnt;
  logic       ex_start_ok;
  logic       ex_done;
  logic       ex_hold;

  // A start while busy is ignored, so only an idle engine accepts it.
  assign ex_start_ok = sb.ex_mc_start && !ex_busy;
  assign ex_done     = ex_busy && (ex_cnt == 6'd0);
  assign ex_hold     = ex_start_ok || (ex_busy && (ex_cnt != 6'd0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_busy <= 1'b0;
      ex_cnt  <= 6'd0;
    end else if (ex_start_ok) begin
      // len 0 behaves like len 1: a single stall cycle.
      ex_cnt  <= (sb.ex_mc_len == 6'd0) ? 6'd0 : sb.ex_mc_len - 6'd1;
      ex_busy <= 1'b1;
    end else if (ex_busy) begin
      if (ex_cnt == 6'd0) begin
        ex_busy <= 1'b0;
      end else begin
        ex_cnt <= ex_cnt - 6'd1;
      end
    end
  end

  // ---- mem wait FSM -------------------------------------------------------
  mem_state_t       mem_state, mem_state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             mem_hold;
  logic             mem_to;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_state <= M_IDLE;
      wait_cnt  <= '0;
    end else begin
      mem_state <= mem_state_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    mem_state_nxt = mem_state;
    wait_cnt_nxt  = wait_cnt;
    mem_hold      = 1'b0;
    mem_to        = 1'b0;
    case (mem_state)
      M_IDLE: begin
        // An ack in the same cycle as the request completes without a wait.
        if (sb.mem_req && !sb.mem_ack) begin
          mem_hold      = 1'b1;
          wait_cnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          mem_state_nxt = M_WAIT;
        end
      end
      M_WAIT: begin
        if (!sb.mem_req || sb.mem_ack) begin
          // Abandoned or completed access: release without a pulse.
          mem_state_nxt = M_IDLE;
        end else if (wait_cnt < TO_CNT) begin
          mem_hold     = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end else begin
          mem_to        = 1'b1;
          mem_state_nxt = M_IDLE;
        end
      end
      default: mem_state_nxt = M_IDLE;
    endcase
  end

  // ---- stall vector -------------------------------------------------------
  logic [5:0] stall_vec;

  always_comb begin
    stall_vec = 6'b000000;
    if (rst) begin
      if (mem_hold)            stall_vec = 6'b011111;
      else if (ex_hold)        stall_vec = 6'b001111;
      else if (sb.stallreq_id) stall_vec = 6'b000111;
      else if (sb.stallreq_if) stall_vec = 6'b000011;
    end
  end

  assign sb.stall       = stall_vec;
  assign sb.ex_mc_busy  = ex_busy;
  // Pulses are masked during reset so an aborted op never reports completion.
  assign sb.ex_mc_done  = rst && ex_done;
  assign sb.mem_timeout = rst && mem_to;

  // ---- stall statistics ---------------------------------------------------
`ifdef STALL_STAT_EN
  logic [31:0] stat_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_cnt <= 32'h0;
    end else if ((stall_vec != 6'b000000) && (stat_cnt != 32'hFFFF_FFFF)) begin
      stat_cnt <= stat_cnt + 32'h1;
    end
  end

  assign sb.stall_cycles = stat_cnt;
`else
  assign sb.stall_cycles = 32'h0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall sequencer for the six-stage pipeline (pc, if, id, ex, mem, wb).
- Collects stall requests from the if and id stages, multi-cycle operations in ex, and the data-memory handshake in mem.
- Drives the shared stall[5:0] vector consumed by the pc register and every inter-stage register, including mem_wb.
- Owns two sequential engines: an ex multi-cycle down-counter and a mem wait FSM with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive mem-wait stall cycles before timeout (legal 2..255)
CNT_W, 8, width of the mem wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
stallreq_if  in  1  fetch stage not ready (level)
stallreq_id  in  1  load-use hazard in id (level)
ex_mc_start  in  1  one-cycle pulse: ex starts a multi-cycle op
ex_mc_len  in  6  cycle count of that op, sampled with ex_mc_start
mem_req  in  1  mem stage has a data-memory access in flight (level)
mem_ack  in  1  data memory completes the access this cycle
stall  out  6  stall vector; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = stop
ex_mc_busy  out  1  multi-cycle op in progress
ex_mc_done  out  1  one-cycle pulse when the op completes
mem_timeout  out  1  one-cycle pulse when a mem wait hits MEM_TIMEOUT
stall_cycles  out  32  stall statistics (see Optional Feature)

Behaviour:
- Reset values (rst=0 at an edge): ex counter 0, ex_mc_busy 0, ex_mc_done 0, mem FSM in M_IDLE, wait count 0, mem_timeout 0.
- While rst=0, stall is forced to 6'b000000 combinationally. Reset mid-operation aborts both engines without emitting any done or timeout pulse.
- stall is combinational from the inputs and the current state, with the latest stage winning:
  - mem_hold: 6'b011111
  - else ex_hold: 6'b001111
  - else stallreq_id: 6'b000111
  - else stallreq_if: 6'b000011
  - else 6'b000000
- wb is never stalled. The mem level inserts a bubble into wb through the mem_wb register.
- Ex engine:
  - In the idle state, ex_mc_start with len N loads the counter with N-1; ex_mc_len=0 is treated as N=1.
  - ex_hold=1 in the start cycle and on every cycle where counter>0 and busy. ex_mc_busy=1 from the cycle after start until done.
  - The counter decrements every cycle and is not frozen by a mem stall.
  - Once the counter reaches 0, the next cycle has ex_hold=0 and ex_mc_done=1, and busy clears.
  - Net result: N stall cycles from the start cycle t, with done at t+N.
  - ex_mc_start while busy is ignored: no reload, no error.
- Mem FSM, states M_IDLE and M_WAIT:
  - M_IDLE: mem_req=1 and mem_ack=0 gives mem_hold=1, wait count := 1, next state M_WAIT. mem_req=1 with mem_ack=1 gives no stall and stays in M_IDLE.
  - M_WAIT, mem_ack=1: mem_hold=0 that cycle, next state M_IDLE.
  - M_WAIT, mem_ack=0 and wait count < MEM_TIMEOUT: mem_hold=1, count+1.
  - M_WAIT, mem_ack=0 and count == MEM_TIMEOUT: mem_hold=0, mem_timeout=1, next state M_IDLE. At most MEM_TIMEOUT stall cycles per access.
  - M_WAIT with mem_req=0: abandoned access, mem_hold=0, next state M_IDLE, no pulse.
  - mem_ack while in M_IDLE with mem_req=0 is ignored.
- Simultaneous events: ex and mem engines run concurrently and independently; only the stall vector is prioritised. ex_mc_done and mem_timeout may pulse in the same cycle.

Optional Feature:
- Macro STALL_STAT_EN.
- When defined:
  - stall_cycles is a 32-bit counter, cleared on reset.
  - Increments on every cycle where stall != 0 and rst=1.
  - Saturates at 32'hFFFFFFFF.
- When undefined: the port remains and is tied to 32'h0; no counter flops are inferred.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all requests high -> stall=000000, busy/done/timeout=0; release -> stall=011111 on the first cycle with rst=1.
- Priority: stallreq_if=1 alone -> 000011; add stallreq_id -> 000111; add mem_req=1, mem_ack=0 -> 011111.
- Multi-cycle: ex_mc_start with len=5 at cycle t -> stall=001111 for t..t+4, ex_mc_done=1 at t+5 only; a second start at t+2 ignored; len=0 -> exactly 1 stall cycle.
- Mem handshake: mem_req rises at t, mem_ack at t+3 -> stall=011111 t..t+2, 000000 at t+3; req and ack together -> no stall.
- Timeout: MEM_TIMEOUT=16, mem_req held high, ack never -> 16 stall cycles, mem_timeout pulse on the 17th cycle, new wait starts the following cycle.
- STALL_STAT_EN: run the multi-cycle len=5 case overlapped with a 3-cycle mem wait starting at t+1 -> stall_cycles=5; without the macro -> 0.
